// File: rtl/carry_skip_add_sequencer.sv
// Multi-cycle add/subtract engine: one shared 4-bit carry-skip slice, one slice per cycle, LSB first.
// Optional ov/zero flag outputs are enabled by defining ALU_SEQ_FLAGS_EN.

module fourbit_carry_skip_block (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       cp
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s  = p ^ c[3:0];
    // When every bit propagates, the incoming carry bypasses the ripple chain.
    cp = (&p) ? c0 : c[4];
  end
endmodule

module carry_skip_add_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             ov,
  output logic             zero,
`endif
  output logic             cout
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
      $error("carry_skip_add_sequencer: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [3:0] slice_s;
  logic       slice_cp;

  always_comb begin
    slice_a = op_a[4*idx +: 4];
    slice_b = op_b[4*idx +: 4];
  end

  fourbit_carry_skip_block u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .c0 (carry),
    .s  (slice_s),
    .cp (slice_cp)
  );

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // read in this block sees the value from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset too; they are few and it keeps the slice inputs defined.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      idx       <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      ov        <= 1'b0;
      zero      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= sub ? ~b : b;
            carry    <= sub;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= slice_s;
          carry           <= slice_cp;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            cout      <= slice_cp;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef ALU_SEQ_FLAGS_EN
            ov   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (slice_s[3] != op_a[WIDTH-1]);
            zero <= (slice_s == 4'd0) && (sum[WIDTH-5:0] == '0);
`endif
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
